morse_digit_tx: RTL

Morse transmitter for decimal digits: accepts a 4-bit digit (0–9) with a start strobe and keys it out as International Morse timing on a single on/off line (LED or buzzer driver). It is the transmit counterpart of the Morse decoder path. It also exposes the digit being sent so the existing 7-segment display logic can show it while it is keyed.

---
 rtl/morse_digit_tx_if.sv | 28 ++
 rtl/morse_digit_tx.sv | 130 +++++++++++++
 2 files changed

// File: rtl/morse_digit_tx_if.sv
// +------------------------------------------------------------------+
// | morse_digit_tx_if : request / keyed-output bundle for the         |
// |                     Morse digit transmitter                       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface morse_digit_tx_if;
   logic [3:0] key;
   logic       start;
   logic       busy;
   logic       done;
   logic       err;
   logic       morse_out;
   logic [3:0] cur_key;

   modport master (
      output key, start,
      input  busy, done, err, morse_out, cur_key
   );

   modport slave (
      input  key, start,
      output busy, done, err, morse_out, cur_key
   );
endinterface

`default_nettype wire

// File: rtl/morse_digit_tx.sv
// +------------------------------------------------------------------+
// | morse_digit_tx : keys a decimal digit out as Morse timing on a    |
// |                  single on/off line                               |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module morse_digit_tx #(
   parameter int UNIT_CYCLES = 25_000_000
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   morse_digit_tx_if.slave   bus
);

   localparam int             C_CW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [C_CW-1:0] C_LAST = C_CW'(UNIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MARK  = 2'd1,
      S_SPACE = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t          state_q;
   logic [C_CW-1:0] cyc_q;
   logic [1:0]      unit_q;
   logic [2:0]      sym_q;
   logic [4:0]      pat_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic            morse_q;
   logic [3:0]      cur_key_q;
   logic [1:0]      unit_last_w;

   // MSB is the next symbol to send; 1 = dash, 0 = dot
   function automatic logic [4:0] digit_pattern(input logic [3:0] d);
      case (d)
         4'd0:    digit_pattern = 5'b11111;
         4'd1:    digit_pattern = 5'b01111;
         4'd2:    digit_pattern = 5'b00111;
         4'd3:    digit_pattern = 5'b00011;
         4'd4:    digit_pattern = 5'b00001;
         4'd5:    digit_pattern = 5'b00000;
         4'd6:    digit_pattern = 5'b10000;
         4'd7:    digit_pattern = 5'b11000;
         4'd8:    digit_pattern = 5'b11100;
         4'd9:    digit_pattern = 5'b11110;
         default: digit_pattern = 5'b00000;
      endcase
   endfunction

   always_comb begin
      unit_last_w = 2'd0;
      if ((state_q == S_MARK && pat_q[4]) || state_q == S_GAP)
         unit_last_w = 2'd2;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cyc_q     <= '0;
         unit_q    <= 2'd0;
         sym_q     <= 3'd0;
         pat_q     <= 5'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         morse_q   <= 1'b0;
         cur_key_q <= 4'd0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (state_q == S_IDLE) begin
            if (bus.start) begin
               if (bus.key <= 4'd9) begin
                  state_q   <= S_MARK;
                  pat_q     <= digit_pattern(bus.key);
                  cur_key_q <= bus.key;
                  cyc_q     <= '0;
                  unit_q    <= 2'd0;
                  sym_q     <= 3'd0;
                  busy_q    <= 1'b1;
                  morse_q   <= 1'b1;
               end else begin
                  err_q <= 1'b1;
               end
            end
         end else if (cyc_q != C_LAST) begin
            cyc_q <= cyc_q + C_CW'(1);
         end else begin
            cyc_q <= '0;
            if (unit_q != unit_last_w) begin
               unit_q <= unit_q + 2'd1;
            end else begin
               // Element finished: outputs change on the same edge as the state
               unit_q <= 2'd0;
               case (state_q)
                  S_MARK: begin
                     morse_q <= 1'b0;
                     state_q <= (sym_q < 3'd4) ? S_SPACE : S_GAP;
                  end
                  S_SPACE: begin
                     morse_q <= 1'b1;
                     sym_q   <= sym_q + 3'd1;
                     pat_q   <= {pat_q[3:0], 1'b0};
                     state_q <= S_MARK;
                  end
                  default: begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.morse_out = morse_q;
   assign bus.cur_key   = cur_key_q;

endmodule

`default_nettype wire
